neopixel_driver: RTL and testbench



---
 rtl/neopixel_driver.sv | 144 ++++++++++++++
 tb/tb_neopixel_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/neopixel_driver.sv
// rtl/neopixel_driver.sv - WS2812 frame buffer and single-wire serializer
module neopixel_driver #(
    parameter int NUM_PIXELS   = 5,
    parameter int BIT_CYCLES   = 63,
    parameter int T0H_CYCLES   = 18,
    parameter int T1H_CYCLES   = 35,
    parameter int RESET_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_color,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send,
    output logic       begin_send,
    output logic       done_send,
    output logic       done_wait
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam int LW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H        = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H        = CW'(T1H_CYCLES);
    localparam logic [PW-1:0] PIX_LAST   = PW'(NUM_PIXELS - 1);
    localparam logic [LW-1:0] LATCH_LAST = LW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, LATCH} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   bit_cyc, bit_cyc_n;
    logic [4:0]      bit_idx, bit_idx_n;
    logic [PW-1:0]   pix, pix_n;
    logic [LW-1:0]   latch_cnt, latch_cnt_n;
    logic            neo_n;
    logic [1:0]      col_sel;
    logic            cur_bit;
    logic [7:0]      pix_mem [NUM_PIXELS][3];

    // Wire order per pixel is green, red, blue; ~bit_idx[2:0] walks MSB first.
    always_comb begin
        if (bit_idx < 5'd8)
            col_sel = 2'd1;
        else if (bit_idx < 5'd16)
            col_sel = 2'd0;
        else
            col_sel = 2'd2;
        cur_bit = pix_mem[pix][col_sel][~bit_idx[2:0]];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PIXELS; p++)
                for (int c = 0; c < 3; c++)
                    pix_mem[p][c] <= 8'h00;
        end else if (state == IDLE && load_color &&
                     int'(pixel_index) < NUM_PIXELS && color_index != 2'd3) begin
            pix_mem[pixel_index][color_index] <= color_level;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cyc   <= '0;
            bit_idx   <= '0;
            pix       <= '0;
            latch_cnt <= '0;
            neo_data  <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cyc   <= bit_cyc_n;
            bit_idx   <= bit_idx_n;
            pix       <= pix_n;
            latch_cnt <= latch_cnt_n;
            neo_data  <= neo_n;
        end
    end

    // neo_n is the line level for the next cycle; every bit starts high.
    always_comb begin
        state_n       = state;
        bit_cyc_n     = bit_cyc;
        bit_idx_n     = bit_idx;
        pix_n         = pix;
        latch_cnt_n   = latch_cnt;
        neo_n         = 1'b0;
        ready_to_load = 1'b0;
        ready_to_send = 1'b0;
        begin_send    = 1'b0;
        done_send     = 1'b0;
        done_wait     = 1'b0;
        case (state)
            IDLE: begin
                ready_to_load = 1'b1;
                ready_to_send = 1'b1;
                if (send_it) begin
                    state_n   = SEND;
                    bit_cyc_n = '0;
                    bit_idx_n = '0;
                    pix_n     = '0;
                    neo_n     = 1'b1;
                end
            end
            SEND: begin
                begin_send = (pix == '0) && (bit_idx == 5'd0) && (bit_cyc == '0);
                if (bit_cyc == BIT_LAST) begin
                    bit_cyc_n = '0;
                    neo_n     = 1'b1;
                    if (bit_idx == 5'd23) begin
                        bit_idx_n = '0;
                        if (pix == PIX_LAST) begin
                            state_n     = LATCH;
                            latch_cnt_n = '0;
                            neo_n       = 1'b0;
                        end else begin
                            pix_n = pix + 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 5'd1;
                    end
                end else begin
                    bit_cyc_n = bit_cyc + 1'b1;
                    neo_n     = bit_cyc_n < (cur_bit ? T1H : T0H);
                end
            end
            LATCH: begin
                done_send = (latch_cnt == '0);
                done_wait = (latch_cnt == LATCH_LAST);
                if (latch_cnt == LATCH_LAST) begin
                    state_n     = IDLE;
                    latch_cnt_n = '0;
                end else begin
                    latch_cnt_n = latch_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_neopixel_driver.sv
// tb/tb_neopixel_driver.sv - self-checking bench for neopixel_driver
module tb_neopixel_driver;
    localparam int NP = 5;
    localparam int BC = 63;
    localparam int T0 = 18;
    localparam int T1 = 35;
    localparam int RC = 2500;
    localparam int F  = NP * 24 * BC;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load_color = 1'b0;
    logic [2:0] pixel_index = '0;
    logic [1:0] color_index = '0;
    logic [7:0] color_level = '0;
    logic       send_it = 1'b0;
    logic       neo_data, ready_to_load, ready_to_send, begin_send, done_send, done_wait;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_buf [NP][3];

    neopixel_driver #(
        .NUM_PIXELS(NP), .BIT_CYCLES(BC), .T0H_CYCLES(T0),
        .T1H_CYCLES(T1), .RESET_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .load_color(load_color),
        .pixel_index(pixel_index), .color_index(color_index),
        .color_level(color_level), .send_it(send_it), .neo_data(neo_data),
        .ready_to_load(ready_to_load), .ready_to_send(ready_to_send),
        .begin_send(begin_send), .done_send(done_send), .done_wait(done_wait)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                model_buf[p][c] = 8'h00;
    endtask

    task automatic model_write(input int p, input int c, input int v);
        if (p < NP && c != 3)
            model_buf[p][c] = v[7:0];
    endtask

    task automatic write_byte(input int p, input int c, input int v);
        load_color  = 1'b1;
        pixel_index = p[2:0];
        color_index = c[1:0];
        color_level = v[7:0];
        @(posedge clock);
        #1 load_color = 1'b0;
        model_write(p, c, v);
    endtask

    // Sends one frame and checks the whole waveform, pulses and ready outputs.
    // ld_cycle >= 0 fires a load mid-frame (must be ignored); same fires a load with send_it.
    task automatic run_frame(input string name, input int ld_cycle, input int ld_p,
                             input int ld_c, input int ld_v, input bit same,
                             input int sp, input int sc, input int sv);
        bit         exp_bits[$];
        logic [23:0] word;
        int highs [NP*24];
        int wave_err = 0, ready_err = 0;
        int b_n = 0, b_at = -1, ds_n = 0, ds_at = -1, dw_n = 0, dw_at = -1;
        if (same) begin
            load_color  = 1'b1;
            pixel_index = sp[2:0];
            color_index = sc[1:0];
            color_level = sv[7:0];
            model_write(sp, sc, sv);
        end
        send_it = 1'b1;
        @(posedge clock);
        #1 send_it = 1'b0;
        load_color = 1'b0;
        for (int p = 0; p < NP; p++) begin
            word = {model_buf[p][1], model_buf[p][0], model_buf[p][2]};
            for (int i = 23; i >= 0; i--) exp_bits.push_back(word[i]);
        end
        for (int k = 0; k < NP*24; k++) highs[k] = 0;
        for (int c = 1; c <= F + RC + 1; c++) begin
            bit exp_neo, exp_rdy;
            @(negedge clock);
            exp_neo = 1'b0;
            if (c <= F) begin
                exp_neo = ((c - 1) % BC) < (exp_bits[(c - 1) / BC] ? T1 : T0);
                if (neo_data === 1'b1) highs[(c - 1) / BC]++;
            end
            if (neo_data !== exp_neo) wave_err++;
            exp_rdy = (c > F + RC);
            if (ready_to_load !== exp_rdy || ready_to_send !== exp_rdy) ready_err++;
            if (begin_send === 1'b1) begin b_n++; b_at = c; end
            if (done_send === 1'b1) begin ds_n++; ds_at = c; end
            if (done_wait === 1'b1) begin dw_n++; dw_at = c; end
            if (c == ld_cycle) begin
                load_color  = 1'b1;
                pixel_index = ld_p[2:0];
                color_index = ld_c[1:0];
                color_level = ld_v[7:0];
            end else if (c == ld_cycle + 1) begin
                load_color = 1'b0;
            end
        end
        for (int k = 0; k < NP*24; k++)
            check($sformatf("%s_bit%0d_high", name, k), highs[k], exp_bits[k] ? T1 : T0);
        check({name, "_wave_err"}, wave_err, 0);
        check({name, "_ready_err"}, ready_err, 0);
        check({name, "_begin_n"}, b_n, 1);
        check({name, "_begin_at"}, b_at, 1);
        check({name, "_dsend_n"}, ds_n, 1);
        check({name, "_dsend_at"}, ds_at, F + 1);
        check({name, "_dwait_n"}, dw_n, 1);
        check({name, "_dwait_at"}, dw_at, F + RC);
    endtask

    initial begin
        int dn;
        clear_model();
        repeat (3) @(negedge clock);
        check("rst_neo", neo_data, 0);
        check("rst_rdy_load", ready_to_load, 1);
        check("rst_rdy_send", ready_to_send, 1);
        check("rst_pulses", {begin_send, done_send, done_wait}, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_neo", neo_data, 0);
            check("idle_rdy", {ready_to_load, ready_to_send}, 3);
            check("idle_pulses", {begin_send, done_send, done_wait}, 0);
        end
        @(posedge clock); #1;
        run_frame("zero", -1, 0, 0, 0, 1'b0, 0, 0, 0);

        @(posedge clock); #1;
        write_byte(0, 0, 'h10);
        write_byte(0, 1, 'h02);
        write_byte(0, 2, 'h16);
        run_frame("pix0", 100, 2, 1, 'hFF, 1'b0, 0, 0, 0);

        @(posedge clock); #1;
        write_byte(5, 1, 'hAA);
        write_byte(7, 0, 'h55);
        write_byte(1, 3, 'hFF);
        run_frame("invalid", -1, 0, 0, 0, 1'b0, 0, 0, 0);

        @(posedge clock); #1;
        for (int i = 0; i < 6; i++)
            write_byte($urandom_range(NP - 1, 0), $urandom_range(2, 0), $urandom_range(255, 0));
        write_byte(4, 2, 'h00);
        run_frame("same_cycle", -1, 0, 0, 0, 1'b1, 4, 2, 'h80);
        check("same_cycle_model_b112", int'(model_buf[4][2]), 'h80);

        @(posedge clock); #1;
        run_frame("resend", 700, 4, 2, 'h01, 1'b0, 0, 0, 0);

        @(posedge clock); #1;
        write_byte(3, 1, $urandom_range(255, 1));
        send_it = 1'b1;
        @(posedge clock);
        #1 send_it = 1'b0;
        for (int c = 1; c <= 2970; c++) @(negedge clock);
        check("abort_pre_high", neo_data, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_neo_async", neo_data, 0);
        check("abort_rdy", {ready_to_load, ready_to_send}, 3);
        check("abort_pulses", {begin_send, done_send, done_wait}, 0);
        clear_model();
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("abort_rel_rdy", {ready_to_load, ready_to_send}, 3);
        dn = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (done_send === 1'b1 || done_wait === 1'b1) dn++;
        end
        check("abort_no_done", dn, 0);
        @(posedge clock); #1;
        run_frame("post_abort", -1, 0, 0, 0, 1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
